// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and EX operand forwarding.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned LD_STALL_CYC = 2,
    parameter int unsigned FLUSH_CYC    = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             pad_clk,
    input  logic             pad_rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [6:0]       ex_opcode,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic             ex_uses_rs1,
    input  logic             ex_uses_rs2,
    input  logic [6:0]       mem_opcode,
    input  logic [4:0]       mem_rd,
    input  logic [6:0]       wb_opcode,
    input  logic [4:0]       wb_rd,
    input  logic             redirect,
    output logic             pc_stuck,
    output logic             if2id_hold,
    output logic             id2ex_bubble,
    output logic             flush_if2id,
    output logic             flush_id2ex,
    output logic             flush_ex2mem,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_OPRI  = 7'b0010011;
    localparam logic [6:0] OP_OPRR  = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] FLUSH_LOAD = (FLUSH_CYC > 0) ? 2'(FLUSH_CYC - 1) : 2'd0;
    localparam logic [1:0] LD_LOAD    = (LD_STALL_CYC > 1) ? 2'(LD_STALL_CYC - 2) : 2'd0;

    typedef enum logic [1:0] {StRun, StLdStall, StFlush} state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       load_use;
    logic       stuck_c, hold_c, bubble_c, fl_if_c, fl_id_c, fl_ex_c;
    logic [1:0] sel1_c, sel2_c;

    function automatic logic is_producer(input logic [6:0] op);
        return (op == OP_OPRI) || (op == OP_OPRR) || (op == OP_LUI) ||
               (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    assign load_use = id_valid && (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge pad_clk or negedge pad_rst_n) begin
        if (!pad_rst_n) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stuck_c  = 1'b0;
        hold_c   = 1'b0;
        bubble_c = 1'b0;
        fl_if_c  = 1'b0;
        fl_id_c  = 1'b0;
        fl_ex_c  = 1'b0;
        // A redirect overrides whatever the FSM was doing, including a pending stall.
        if (redirect) begin
            fl_if_c = 1'b1;
            fl_id_c = 1'b1;
            fl_ex_c = 1'b1;
            state_d = (FLUSH_CYC > 0) ? StFlush : StRun;
            cnt_d   = FLUSH_LOAD;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (load_use) begin
                        stuck_c  = 1'b1;
                        hold_c   = 1'b1;
                        bubble_c = 1'b1;
                        if (LD_STALL_CYC > 1) begin
                            state_d = StLdStall;
                            cnt_d   = LD_LOAD;
                        end
                    end
                end
                StLdStall: begin
                    stuck_c  = 1'b1;
                    hold_c   = 1'b1;
                    bubble_c = 1'b1;
                    if (cnt_q == 2'd0) state_d = StRun;
                    else               cnt_d   = cnt_q - 2'd1;
                end
                StFlush: begin
                    fl_if_c = 1'b1;
                    if (cnt_q == 2'd0) state_d = StRun;
                    else               cnt_d   = cnt_q - 2'd1;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        sel1_c = 2'b00;
        sel2_c = 2'b00;
        if (ex_uses_rs1 && is_producer(mem_opcode) && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
            sel1_c = 2'b01;
        else if (ex_uses_rs1 && ((wb_opcode == OP_LOAD) || is_producer(wb_opcode)) &&
                 (wb_rd != 5'd0) && (wb_rd == ex_rs1))
            sel1_c = 2'b10;
        if (ex_uses_rs2 && is_producer(mem_opcode) && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
            sel2_c = 2'b01;
        else if (ex_uses_rs2 && ((wb_opcode == OP_LOAD) || is_producer(wb_opcode)) &&
                 (wb_rd != 5'd0) && (wb_rd == ex_rs2))
            sel2_c = 2'b10;
    end

    // Outputs are forced low while reset is asserted, independent of the inputs.
    assign pc_stuck     = stuck_c  & pad_rst_n;
    assign if2id_hold   = hold_c   & pad_rst_n;
    assign id2ex_bubble = bubble_c & pad_rst_n;
    assign flush_if2id  = fl_if_c  & pad_rst_n;
    assign flush_id2ex  = fl_id_c  & pad_rst_n;
    assign flush_ex2mem = fl_ex_c  & pad_rst_n;
    assign fwd_rs1_sel  = sel1_c & {2{pad_rst_n}};
    assign fwd_rs2_sel  = sel2_c & {2{pad_rst_n}};

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge pad_clk or negedge pad_rst_n) begin
        if (!pad_rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_stuck && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
            if (redirect && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LD_STALL_CYC=2, FLUSH_CYC=1, CNT_W=4).
module tb_hazard_ctrl;

    localparam logic [6:0] LOAD = 7'b0000011;
    localparam logic [6:0] OPRR = 7'b0110011;

    logic       pad_clk = 1'b0;
    logic       pad_rst_n = 1'b0;
    logic       id_valid, id_uses_rs1, id_uses_rs2, ex_uses_rs1, ex_uses_rs2, redirect;
    logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic [6:0] ex_opcode, mem_opcode, wb_opcode;
    logic       pc_stuck, if2id_hold, id2ex_bubble, flush_if2id, flush_id2ex, flush_ex2mem;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic [3:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail = 0;

    hazard_ctrl #(.LD_STALL_CYC(2), .FLUSH_CYC(1), .CNT_W(4)) dut (
        .pad_clk(pad_clk), .pad_rst_n(pad_rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2), .mem_opcode(mem_opcode),
        .mem_rd(mem_rd), .wb_opcode(wb_opcode), .wb_rd(wb_rd), .redirect(redirect),
        .pc_stuck(pc_stuck), .if2id_hold(if2id_hold), .id2ex_bubble(id2ex_bubble),
        .flush_if2id(flush_if2id), .flush_id2ex(flush_id2ex), .flush_ex2mem(flush_ex2mem),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 pad_clk = ~pad_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {pc_stuck, if2id_hold, id2ex_bubble, flush_if2id, flush_id2ex, flush_ex2mem}
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, pc_stuck, if2id_hold, id2ex_bubble,
                  flush_if2id, flush_id2ex, flush_ex2mem}, {26'd0, exp});
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_opcode = 0; ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0; ex_uses_rs1 = 0; ex_uses_rs2 = 0;
        mem_opcode = 0; mem_rd = 0; wb_opcode = 0; wb_rd = 0; redirect = 0;
    endtask

    // lw x5 in EX, add x6,x5,x1 in ID
    task automatic set_load_use();
        idle();
        ex_opcode = LOAD; ex_rd = 5'd5;
        id_valid = 1; id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs1 = 1; id_uses_rs2 = 1;
    endtask

    task automatic step();
        @(posedge pad_clk);
        #1;
    endtask

    initial begin
        idle();
        // Inputs that would otherwise flush/stall must be masked while in reset.
        set_load_use();
        redirect = 1;
        ex_uses_rs1 = 1; ex_rs1 = 5'd3; mem_opcode = OPRR; mem_rd = 5'd3;
        #12;
        chk_ctl("reset_ctl", 6'b000000);
        chk("reset_fwd", {30'd0, fwd_rs1_sel}, 32'd0);
        chk("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("reset_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        idle();
        #1 pad_rst_n = 1;

        // Load-use stall: exactly two stall cycles, then forward from WB.
        step(); set_load_use(); #1;
        chk_ctl("stall_c0", 6'b111000);
        step(); ex_opcode = 0; ex_rd = 0; mem_opcode = LOAD; mem_rd = 5'd5; #1;
        chk_ctl("stall_c1", 6'b111000);
        step(); mem_opcode = 0; mem_rd = 0; wb_opcode = LOAD; wb_rd = 5'd5; #1;
        chk_ctl("stall_done", 6'b000000);
        step(); id_valid = 0;
        ex_opcode = OPRR; ex_rd = 5'd6; ex_rs1 = 5'd5; ex_rs2 = 5'd1;
        ex_uses_rs1 = 1; ex_uses_rs2 = 1; mem_opcode = LOAD; mem_rd = 5'd1; #1;
        chk("fwd_wb_load_rs1", {30'd0, fwd_rs1_sel}, 32'd2);
        chk("fwd_mem_load_rs2", {30'd0, fwd_rs2_sel}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt_2", {28'd0, stall_cnt}, 32'd2);
`else
        chk("stall_cnt_off", {28'd0, stall_cnt}, 32'd0);
`endif

        // Redirect beats a simultaneous load-use.
        step(); set_load_use(); redirect = 1; #1;
        chk_ctl("prio_c0", 6'b000111);
        step(); idle(); #1;
        chk_ctl("prio_c1", 6'b000100);
        step(); #1;
        chk_ctl("prio_c2", 6'b000000);

        // Back-to-back redirect reloads the flush counter.
        step(); redirect = 1; #1;
        chk_ctl("b2b_c0", 6'b000111);
        step(); #1;
        chk_ctl("b2b_c1", 6'b000111);
        step(); redirect = 0; #1;
        chk_ctl("b2b_c2", 6'b000100);
        step(); #1;
        chk_ctl("b2b_c3", 6'b000000);

        // Redirect during LDSTALL aborts the stall and enters FLUSH.
        step(); set_load_use(); #1;
        chk_ctl("ldabort_c0", 6'b111000);
        step(); idle(); redirect = 1; #1;
        chk_ctl("ldabort_c1", 6'b000111);
        step(); redirect = 0; #1;
        chk_ctl("ldabort_c2", 6'b000100);
        step(); #1;
        chk_ctl("ldabort_c3", 6'b000000);

        // Forwarding priority and x0 exclusion.
        ex_opcode = OPRR; ex_rs1 = 5'd7; ex_rs2 = 5'd7; ex_uses_rs1 = 1; ex_uses_rs2 = 1;
        mem_opcode = OPRR; mem_rd = 5'd7; wb_opcode = LOAD; wb_rd = 5'd7; #1;
        chk("fwd_order", {28'd0, fwd_rs1_sel, fwd_rs2_sel}, 32'b0101);
        mem_rd = 5'd3; #1;
        chk("fwd_wb_only", {28'd0, fwd_rs1_sel, fwd_rs2_sel}, 32'b1010);
        ex_uses_rs2 = 0; #1;
        chk("fwd_unused", {28'd0, fwd_rs1_sel, fwd_rs2_sel}, 32'b1000);
        ex_uses_rs2 = 1; ex_rs1 = 5'd0; ex_rs2 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; #1;
        chk("fwd_x0", {28'd0, fwd_rs1_sel, fwd_rs2_sel}, 32'b0000);

        // Reset mid-stall.
        step(); set_load_use(); #1;
        step(); #1;
        chk_ctl("rst_pre", 6'b111000);
        pad_rst_n = 0; #1;
        chk_ctl("rst_async", 6'b000000);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
        #1 pad_rst_n = 1; ex_opcode = 0; #1;
        chk_ctl("rst_released", 6'b000000);
        step(); #1;
        chk_ctl("rst_no_stall", 6'b000000);

        // Saturation: 20 stall cycles and 17 redirect cycles.
        set_load_use();
        for (int i = 0; i < 20; i++) step();
        idle(); redirect = 1;
        for (int i = 0; i < 17; i++) step();
        idle(); #1;
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
        chk("flush_sat", {28'd0, flush_cnt}, 32'd15);
`else
        chk("stall_off", {28'd0, stall_cnt}, 32'd0);
        chk("flush_off", {28'd0, flush_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
